// File: rtl/alu_mc_pkg.sv
// Operation codes and controller state encoding shared by the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_OR   = 4'h2;
    localparam logic [3:0] OP_SLT  = 4'h3;
    localparam logic [3:0] OP_SLTU = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOR  = 4'h7;
    localparam logic [3:0] OP_SLL  = 4'h8;
    localparam logic [3:0] OP_SRL  = 4'h9;
    localparam logic [3:0] OP_SRA  = 4'hA;
    localparam logic [3:0] OP_MULU = 4'hB;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mc_mul_shift_add.sv
// Iterative unsigned multiplier: the multiplier sits in the low half of the
// product register and is consumed one bit per cycle by a conditional add of
// the multiplicand into the high half followed by a right shift.
module mul_shift_add
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int SHW = $clog2(WIDTH);

    logic             busy_q, busy_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH:0]   sum;

    // Load operands on start, then perform one shift-add step per busy cycle
    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        if (busy_q) begin
            {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
            cnt_d        = cnt_q - SHW'(1);
            if (cnt_q == '0) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end else if (start_i) begin
            hi_d    = '0;
            lo_d    = b_i;
            mcand_d = a_i;
            cnt_d   = SHW'(WIDTH - 1);
            busy_d  = 1'b1;
        end
    end

    // Step counter and busy flag; reset aborts any multiply in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Product and multiplicand registers carry data only
    always_ff @(posedge clk) begin
        hi_q    <= hi_d;
        lo_q    <= lo_d;
        mcand_q <= mcand_d;
    end

    // The last step's outcome is presented directly so the caller can
    // register it on the same edge the multiplier goes idle.
    assign busy_o         = busy_q;
    assign done_o         = busy_q && (cnt_q == '0);
    assign {hi_o, lo_o}   = {sum, lo_q[WIDTH-1:1]};

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle logic/arith/shift
// ops and an iterative unsigned multiply, feeding one registered output stage.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             overflow,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    state_e                  state_q, state_d;
    logic                    accept, start_mul;
    logic                    mul_busy, mul_done;
    logic [WIDTH-1:0]        mul_hi, mul_lo;
    logic [SHW-1:0]          sh;
    logic signed [WIDTH-1:0] a_s;
    logic [WIDTH:0]          add_w, sub_w;
    logic                    add_ovf, sub_ovf;
    logic [WIDTH-1:0]        res_c;
    logic                    ovf_c;
    logic                    out_valid_q, out_valid_d;
    logic [WIDTH-1:0]        result_q, result_d;
    logic [WIDTH-1:0]        result_hi_q, result_hi_d;
    logic                    overflow_q, overflow_d;
    logic                    zero_q, zero_d;

    assign in_ready  = !rst && (state_q == IDLE) && !mul_busy && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign start_mul = accept && (op == OP_MULU);
    assign sh        = b[SHW-1:0];
    assign a_s       = a;

    mul_shift_add #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_mul),
        .a_i     (a),
        .b_i     (b),
        .busy_o  (mul_busy),
        .done_o  (mul_done),
        .hi_o    (mul_hi),
        .lo_o    (mul_lo)
    );

    // Single-cycle operations; subtract-based ops share a + ~b + 1
    always_comb begin
        add_w   = {1'b0, a} + {1'b0, b};
        sub_w   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
        sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
        res_c   = '0;
        ovf_c   = 1'b0;
        case (op)
            OP_ADD:  begin res_c = add_w[WIDTH-1:0]; ovf_c = add_ovf; end
            OP_SUB:  begin res_c = sub_w[WIDTH-1:0]; ovf_c = sub_ovf; end
            OP_OR:   res_c = a | b;
            OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, sub_w[WIDTH-1] ^ sub_ovf};
            OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, ~sub_w[WIDTH]};
            OP_AND:  res_c = a & b;
            OP_XOR:  res_c = a ^ b;
            OP_NOR:  res_c = ~(a | b);
            OP_SLL:  res_c = a << sh;
            OP_SRL:  res_c = a >> sh;
            OP_SRA:  res_c = a_s >>> sh;
            default: res_c = '0;
        endcase
    end

    // Controller next state: only a multiply leaves IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_mul) state_d = BUSY;
            BUSY:    if (mul_done)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Controller state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Output stage: drain on out_ready, load on single-cycle accept or multiply completion
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (accept && (op != OP_MULU)) begin
            result_d    = res_c;
            result_hi_d = '0;
            overflow_d  = ovf_c;
            zero_d      = (res_c == '0);
            out_valid_d = 1'b1;
        end else if ((state_q == BUSY) && mul_done) begin
            result_d    = mul_lo;
            result_hi_d = mul_hi;
            overflow_d  = 1'b0;
            zero_d      = ({mul_hi, mul_lo} == '0);
            out_valid_d = 1'b1;
        end
    end

    // Output registers, cleared by reset so a discarded op leaves no trace
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed cases with literal expectations plus randomized
// traffic scored every cycle against an arithmetic model of the ALU.
module tb_alu_mc;

    localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, OR_ = 4'h2, SLT = 4'h3, SLTU = 4'h4;
    localparam logic [3:0] AND_ = 4'h5, XOR_ = 4'h6, NOR_ = 4'h7, SLL = 4'h8, SRL = 4'h9;
    localparam logic [3:0] SRA = 4'hA, MULU = 4'hB;

    typedef struct {
        logic [63:0] lo;
        logic [63:0] hi;
        logic        ovf;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [3:0]  op = 4'h0;
    logic [31:0] a = '0, b = '0, result, result_hi;
    logic        overflow, zero;

    logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1;
    logic [3:0]  op8 = 4'h0;
    logic [7:0]  a8 = '0, b8 = '0, result8, result_hi8;
    logic        overflow8, zero8;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   clean = 1'b1;
    exp_t q[$];

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .result_hi(result_hi), .overflow(overflow), .zero(zero)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
        .result_hi(result_hi8), .overflow(overflow8), .zero(zero8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // What the ALU must produce, from plain integer arithmetic on w-bit values
    function automatic exp_t model(input int w, input logic [3:0] o,
                                   input logic [63:0] x_in, input logic [63:0] y_in);
        exp_t        e;
        logic [63:0] mask, x, y, p;
        longint      sx, sy, r, mn, mx;
        int          sh;
        mask = (64'd1 << w) - 64'd1;
        x    = x_in & mask;
        y    = y_in & mask;
        sx   = longint'(x);
        sy   = longint'(y);
        if (x[w-1]) sx = sx - (longint'(1) << w);
        if (y[w-1]) sy = sy - (longint'(1) << w);
        mn   = -(longint'(1) << (w - 1));
        mx   = (longint'(1) << (w - 1)) - 1;
        sh   = int'(y % 64'(w));
        e.lo = '0; e.hi = '0; e.ovf = 1'b0; e.due = 0;
        case (o)
            ADD:  begin r = sx + sy; e.ovf = (r < mn) || (r > mx); e.lo = 64'(r) & mask; end
            SUB:  begin r = sx - sy; e.ovf = (r < mn) || (r > mx); e.lo = 64'(r) & mask; end
            OR_:  e.lo = x | y;
            SLT:  e.lo = (sx < sy) ? 64'd1 : 64'd0;
            SLTU: e.lo = (x < y) ? 64'd1 : 64'd0;
            AND_: e.lo = x & y;
            XOR_: e.lo = x ^ y;
            NOR_: e.lo = ~(x | y) & mask;
            SLL:  e.lo = (x << sh) & mask;
            SRL:  e.lo = x >> sh;
            SRA:  e.lo = 64'(sx >>> sh) & mask;
            MULU: begin p = x * y; e.lo = p & mask; e.hi = (p >> w) & mask; end
            default: ;
        endcase
        return e;
    endfunction

    // Per-cycle scoreboard for the 32-bit instance
    always @(negedge clk) begin
        bit   ev, busy, eir;
        exp_t e;
        if (cyc >= 1) begin
            ev   = (q.size() > 0) && (q[0].due <= cyc);
            busy = (q.size() > 0) && (q[0].due > cyc);
            eir  = !rst && !busy && (!ev || out_ready);
            chk("out_valid", 64'(out_valid), 64'(ev));
            chk("in_ready", 64'(in_ready), 64'(eir));
            if (ev) begin
                chk("result", 64'(result), q[0].lo);
                chk("result_hi", 64'(result_hi), q[0].hi);
                chk("overflow", 64'(overflow), 64'(q[0].ovf));
                chk("zero", 64'(zero), 64'((q[0].lo == 0) && (q[0].hi == 0)));
            end else if (clean) begin
                chk("reset outputs", {30'd0, result, overflow, zero},
                    64'd0);
                chk("reset result_hi", 64'(result_hi), 64'd0);
            end
            if (rst) begin
                q.delete();
                clean = 1'b1;
            end else begin
                if (ev && out_ready) void'(q.pop_front());
                if (in_valid && eir) begin
                    e     = model(32, op, 64'(a), 64'(b));
                    e.due = cyc + ((op == MULU) ? 33 : 1);
                    q.push_back(e);
                    clean = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int k);
        int t;
        t = 0;
        op = o; a = x; b = y; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("issue accepted", 64'(in_ready), 64'd1);
        k = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15));
    endtask

    task automatic run1(input string nm, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] elo, input logic [31:0] ehi,
                        input logic eovf, input logic ez, input int elat);
        int k, t, irh;
        issue(o, x, y, k);
        irh = 0; t = 0;
        while (1) begin
            @(negedge clk);
            if (out_valid) break;
            if (in_ready) irh++;
            t++;
            if (t > 100) break;
        end
        chk({nm, " latency"}, 64'(cyc - k), 64'(elat));
        chk({nm, " result"}, 64'(result), 64'(elo));
        chk({nm, " result_hi"}, 64'(result_hi), 64'(ehi));
        chk({nm, " overflow"}, 64'(overflow), 64'(eovf));
        chk({nm, " zero"}, 64'(zero), 64'(ez));
        chk({nm, " in_ready while busy"}, 64'(irh), 64'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k, t, seen;
        exp_t pin;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        pin = model(32, SRA, 64'h8000_0000, 64'd24);
        chk("model SRA", pin.lo, 64'hFFFF_FF80);
        pin = model(32, MULU, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        chk("model MULU hi", pin.hi, 64'hFFFF_FFFE);

        run1("ADD ovf", ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 1);
        run1("SUB zero", SUB, 32'd5, 32'd5, 32'h0, 32'h0, 1'b0, 1'b1, 1);
        run1("SLT", SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h0, 1'b0, 1'b0, 1);
        run1("SLTU", SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b0, 1'b1, 1);
        run1("SRA", SRA, 32'h8000_0000, 32'd24, 32'hFFFF_FF80, 32'h0, 1'b0, 1'b0, 1);
        run1("SUB ovf", SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 1);
        run1("NOR", NOR_, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1);
        run1("SLL upper b", SLL, 32'h1, 32'h21, 32'h2, 32'h0, 1'b0, 1'b0, 1);
        run1("SRL", SRL, 32'h8000_0000, 32'd31, 32'h1, 32'h0, 1'b0, 1'b0, 1);
        run1("MULU max", MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 1'b0, 1'b0, 33);

        // Backpressure: hold a result, queue an ADD, then drain and accept together
        out_ready = 1'b0;
        issue(XOR_, 32'hF0F0_F0F0, 32'hFFFF_0000, k);
        in_valid = 1'b1; op = ADD; a = 32'd2; b = 32'd3;
        repeat (5) begin
            @(negedge clk);
            chk("stall out_valid", 64'(out_valid), 64'd1);
            chk("stall result", 64'(result), 64'h0F0F_F0F0);
            chk("stall in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("drain+accept in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("after drain out_valid", 64'(out_valid), 64'd1);
        chk("after drain result", 64'(result), 64'd5);
        @(posedge clk); #1;

        // Reset at BUSY cycle 10 of a multiply
        issue(MULU, 32'h1234_5678, 32'h9ABC_DEF0, k);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort out_valid", 64'(out_valid), 64'd0);
        chk("abort result", 64'(result), 64'd0);
        chk("abort result_hi", 64'(result_hi), 64'd0);
        chk("abort flags", {62'd0, overflow, zero}, 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort no output", 64'(seen), 64'd0);
        @(posedge clk); #1;
        run1("ADD after rst", ADD, 32'd2, 32'd3, 32'd5, 32'h0, 1'b0, 1'b0, 1);
        run1("reserved D", 4'hD, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 1'b1, 1);

        // 8-bit instance multiply
        in_valid8 = 1'b1; op8 = MULU; a8 = 8'hFF; b8 = 8'hFF;
        @(negedge clk);
        chk("w8 in_ready", 64'(in_ready8), 64'd1);
        k = cyc;
        @(posedge clk); #1 in_valid8 = 1'b0;
        t = 0;
        while (1) begin
            @(negedge clk);
            if (out_valid8 || t > 40) break;
            t++;
        end
        chk("w8 latency", 64'(cyc - k), 64'd9);
        chk("w8 hi", 64'(result_hi8), 64'hFE);
        chk("w8 lo", 64'(result8), 64'h01);
        chk("w8 zero", 64'(zero8), 64'd0);
        @(posedge clk); #1;

        // Randomized traffic, checked by the scoreboard
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            op        = 4'($urandom_range(0, 15));
            a         = pick();
            b         = pick();
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 299) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("scoreboard drained", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
